seg_display_ctrl: RTL

Parametrised successor to the single-value seven-segment driver: a time-multiplexed controller for DIGITS common-anode digits with hex or decimal rendering, leading-zero blanking, per-digit decimal points and overflow indication. It sits on the fast board clock beside the core and takes a value word (e.g. the data-memory display register) plus a load strobe. Decimal mode uses a sequential double-dabble converter; the visible value updates atomically only when conversion completes.

---
 rtl/seg_pkg.sv | 42 ++++
 rtl/seg_display_ctrl_if.sv | 17 +
 rtl/seg_bin2bcd.sv | 68 ++++++
 rtl/seg_display_ctrl.sv | 102 ++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment controller.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } seg_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic logic [6:0] nib2seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Decimal digits needed for an unsigned DATA_W-bit value: floor(w*log10(2))+1.
  function automatic int bcd_digits(input int data_w);
    return (data_w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Value/load port of the display controller, plus the conversion FSM state.
// Handshake: load is a one-cycle strobe taken only in a cycle where busy is low; while busy is high loads are dropped (no ready, no queue).
interface seg_display_ctrl_if #(
  parameter int DATA_W = 32
);
  import seg_pkg::*;

  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              mode;
  logic              busy;
  seg_state_e        state;

  modport master (output data_in, load, mode, input busy, state);
  modport slave  (input data_in, load, mode, output busy, state);

endinterface

// File: rtl/seg_bin2bcd.sv
// Sequential double-dabble: one shift per cycle, result held stable in COMMIT.
module seg_bin2bcd
  import seg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BCD_N  = bcd_digits(DATA_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DATA_W-1:0]  bin_in,
  output logic               busy,
  output logic               done,
  output logic [4*BCD_N-1:0] bcd,
  output seg_state_e         state
);

  localparam int CNT_W = $clog2(DATA_W);

  seg_state_e         state_next;
  logic [DATA_W-1:0]  bin_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [4*BCD_N-1:0] bcd_adj;
  logic               last_bit;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    last_bit   = (cnt_q == CNT_W'(DATA_W - 1));
    case (state)
      ST_IDLE:   if (start) state_next = ST_SHIFT;
      ST_SHIFT:  if (last_bit) state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_N; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q <= '0;
      cnt_q <= '0;
      bcd   <= '0;
    end else if (state == ST_IDLE && start) begin
      bin_q <= bin_in;
      cnt_q <= '0;
      bcd   <= '0;
    end else if (state == ST_SHIFT) begin
      bcd   <= {bcd_adj[4*BCD_N-2:0], bin_q[DATA_W-1]};
      bin_q <= bin_q << 1;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_COMMIT);

endmodule

// File: rtl/seg_display_ctrl.sv
// Time-multiplexed common-anode display controller: hex or decimal rendering,
// leading-zero blanking, per-digit decimal points and overflow dashes.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int DATA_W      = 32,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  seg_display_ctrl_if.slave bus,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  output logic [6:0]        ledOut,
  output logic              dpOut,
  output logic [DIGITS-1:0] Anodeselect
);

  localparam int BCD_N = bcd_digits(DATA_W);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [4*DIGITS-1:0] disp_q;
  logic                ovf_q;
  logic [4*BCD_N-1:0]  bcd;
  logic                conv_busy;
  logic                conv_done;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DIGITS-1:0]   zero_from;
  logic                zf;
  logic [6:0]          glyph;

  seg_bin2bcd #(
    .DATA_W(DATA_W),
    .BCD_N (BCD_N)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (bus.load & bus.mode),
    .bin_in(bus.data_in),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd),
    .state (bus.state)
  );

  assign bus.busy = conv_busy;

  // Decimal results land atomically in COMMIT; hex loads only while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else if (conv_done) begin
      disp_q <= (4*DIGITS)'(bcd);
      ovf_q  <= |(bcd >> (4*DIGITS));
    end else if (bus.load && !bus.mode && !conv_busy) begin
      disp_q <= (4*DIGITS)'(bus.data_in);
      ovf_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_q <= '0;
      idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // zero_from[i]: nibbles i..DIGITS-1 are all zero.
  always_comb begin
    zero_from = '0;
    zf        = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zf           = zf && (disp_q[4*i +: 4] == 4'd0);
      zero_from[i] = zf;
    end
    if (ovf_q)                                        glyph = SEG_DASH;
    else if (blank_lz && idx_q != '0 && zero_from[idx_q]) glyph = SEG_BLANK;
    else                                              glyph = nib2seg(disp_q[4*idx_q +: 4]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ledOut      <= SEG_BLANK;
      dpOut       <= 1'b1;
      Anodeselect <= '1;
    end else begin
      ledOut      <= glyph;
      dpOut       <= ~dp_mask[idx_q];
      Anodeselect <= ~(DIGITS'(1) << idx_q);
    end
  end

endmodule
